// File: rtl/core_test_ctrl_if.sv
// Snoop view of the core's data-memory write bus; the core side drives it,
// the run controller only observes it.
interface core_test_ctrl_if #(
    parameter int DATAWIDTH = 32
);
    logic                 TESTCTRL_Datamem_Write_in;
    logic [DATAWIDTH-1:0] TESTCTRL_Datamem_Addr_InBUS;
    logic [DATAWIDTH-1:0] TESTCTRL_Datamem_Writedata_InBUS;
    logic [3:0]           TESTCTRL_Datamem_Byteenable_InBUS;

    modport master (
        output TESTCTRL_Datamem_Write_in,
        output TESTCTRL_Datamem_Addr_InBUS,
        output TESTCTRL_Datamem_Writedata_InBUS,
        output TESTCTRL_Datamem_Byteenable_InBUS
    );

    modport slave (
        input TESTCTRL_Datamem_Write_in,
        input TESTCTRL_Datamem_Addr_InBUS,
        input TESTCTRL_Datamem_Writedata_InBUS,
        input TESTCTRL_Datamem_Byteenable_InBUS
    );
endinterface

// File: rtl/core_test_ctrl.sv
// Run controller: sequences core reset release, bounds the run with a cycle
// timeout and ends it on a full-word store to the tohost mailbox.
module core_test_ctrl #(
    parameter int                   DATAWIDTH      = 32,
    parameter int                   CNT_WIDTH      = 32,
    parameter int                   RST_CYCLES     = 4,
    parameter int                   TIMEOUT_CYCLES = 150,
    parameter logic [DATAWIDTH-1:0] TOHOST_ADDR    = 32'h000003FC
) (
    input  logic                 TESTCTRL_Clk_in,
    input  logic                 TESTCTRL_Reset_in,
    input  logic                 TESTCTRL_Start_in,
    core_test_ctrl_if.slave      dmem_if,
    output logic                 TESTCTRL_Core_Reset_n_Out,
    output logic                 TESTCTRL_Busy_Out,
    output logic                 TESTCTRL_Done_Out,
    output logic                 TESTCTRL_Pass_Out,
    output logic                 TESTCTRL_Timeout_Out,
    output logic [DATAWIDTH-2:0] TESTCTRL_Exitcode_OutBUS,
    output logic [CNT_WIDTH-1:0] TESTCTRL_Cycles_OutBUS,
    output logic [CNT_WIDTH-1:0] TESTCTRL_Stores_OutBUS
);

    localparam int                   RW          = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]        RST_LOAD    = RW'(RST_CYCLES - 1);
    localparam logic                 TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [DATAWIDTH-1:0] PASS_VAL    = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t                 state_q, state_d;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic [DATAWIDTH-2:0]   exit_q, exit_d;
    logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]   stores_q, stores_d;

    logic                   hit_s;
    logic                   tmo_now_s;
    logic [CNT_WIDTH-1:0]   cyc_inc_s;

    // Mailbox decode and timeout detection on the would-be cycle count
    always_comb begin
        hit_s     = dmem_if.TESTCTRL_Datamem_Write_in
                  && (dmem_if.TESTCTRL_Datamem_Addr_InBUS == TOHOST_ADDR)
                  && (dmem_if.TESTCTRL_Datamem_Byteenable_InBUS == 4'hF);
        cyc_inc_s = sat_inc(cycles_q);
        tmo_now_s = TIMEOUT_EN && (cyc_inc_s == TIMEOUT_VAL);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        exit_d       = exit_q;
        cycles_d     = cycles_q;
        stores_d     = stores_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (TESTCTRL_Start_in) begin
                    state_d      = ST_RESET;
                    rst_cnt_d    = RST_LOAD;
                    core_rst_n_d = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    exit_d       = {(DATAWIDTH-1){1'b0}};
                    cycles_d     = {CNT_WIDTH{1'b0}};
                    stores_d     = {CNT_WIDTH{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == {RW{1'b0}}) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q - {{(RW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                cycles_d = cyc_inc_s;
                if (dmem_if.TESTCTRL_Datamem_Write_in) begin
                    stores_d = sat_inc(stores_q);
                end else begin
                    stores_d = stores_q;
                end
                // A mailbox hit takes priority over a coincident timeout
                if (hit_s) begin
                    state_d      = ST_DONE;
                    core_rst_n_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    pass_d       = (dmem_if.TESTCTRL_Datamem_Writedata_InBUS == PASS_VAL);
                    exit_d       = dmem_if.TESTCTRL_Datamem_Writedata_InBUS[DATAWIDTH-1:1];
                end else if (tmo_now_s) begin
                    state_d      = ST_DONE;
                    core_rst_n_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    timeout_d    = 1'b1;
                    pass_d       = 1'b0;
                    exit_d       = {(DATAWIDTH-1){1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                core_rst_n_d = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge TESTCTRL_Clk_in or posedge TESTCTRL_Reset_in) begin
        if (TESTCTRL_Reset_in) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= {RW{1'b0}};
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            exit_q       <= {(DATAWIDTH-1){1'b0}};
            cycles_q     <= {CNT_WIDTH{1'b0}};
            stores_q     <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            exit_q       <= exit_d;
            cycles_q     <= cycles_d;
            stores_q     <= stores_d;
        end
    end

    assign TESTCTRL_Core_Reset_n_Out = core_rst_n_q;
    assign TESTCTRL_Busy_Out         = busy_q;
    assign TESTCTRL_Done_Out         = done_q;
    assign TESTCTRL_Pass_Out         = pass_q;
    assign TESTCTRL_Timeout_Out      = timeout_q;
    assign TESTCTRL_Exitcode_OutBUS  = exit_q;
    assign TESTCTRL_Cycles_OutBUS    = cycles_q;
    assign TESTCTRL_Stores_OutBUS    = stores_q;

endmodule

// File: doc/core_test_ctrl.md
# core_test_ctrl

Synthesizable run controller for the RISC-V core verification harness and FPGA bring-up: sequences the core's reset release and bounds each run with a cycle timeout. It ends the run on a "tohost" mailbox store snooped from the core's data-memory bus. It sits between the harness clock/reset and the CORE reset input, alongside DATAMEM on the core's data-memory write bus. It reports pass/fail, exit code, cycle count and store count.

## Interface
- DATAWIDTH, 32, data/address bus width
- CNT_WIDTH, 32, width of cycle and store counters
- RST_CYCLES, 4, cycles the core is held in reset after a start (must be ≥1)
- TIMEOUT_CYCLES, 150, maximum RUN cycles; 0 disables timeout
- TOHOST_ADDR, 32'h000003FC, mailbox word address
- TESTCTRL_Clk_in  in  1  single clock, rising edge
- TESTCTRL_Reset_in  in  1  reset, asynchronous, active-high
- TESTCTRL_Start_in  in  1  start request, sampled at posedge
- TESTCTRL_Datamem_Write_in  in  1  core data-memory write strobe
- TESTCTRL_Datamem_Addr_InBUS  in  DATAWIDTH  core data-memory address
- TESTCTRL_Datamem_Writedata_InBUS  in  DATAWIDTH  core write data
- TESTCTRL_Datamem_Byteenable_InBUS  in  4  core byte enables
- TESTCTRL_Core_Reset_n_Out  out  1  core reset, low = core held in reset
- TESTCTRL_Busy_Out  out  1  state is RESET or RUN
- TESTCTRL_Done_Out  out  1  state is DONE
- TESTCTRL_Pass_Out  out  1  run ended by mailbox value 1
- TESTCTRL_Timeout_Out  out  1  run ended by timeout
- TESTCTRL_Exitcode_OutBUS  out  DATAWIDTH-1  mailbox data[DATAWIDTH-1:1] captured at end
- TESTCTRL_Cycles_OutBUS  out  CNT_WIDTH  RUN cycles elapsed
- TESTCTRL_Stores_OutBUS  out  CNT_WIDTH  data-memory writes seen in RUN

## Operation
- All outputs are registered.
- Reset values:
  - FSM = IDLE; Core_Reset_n = 0.
  - Busy, Done, Pass and Timeout = 0.
  - Exitcode, Cycles and Stores = 0.
- FSM states and transitions:
  - IDLE: Start=1 → RESET. Clears Pass, Timeout, Exitcode, Cycles and Stores; loads the reset counter.
  - RESET: Core_Reset_n = 0 for exactly RST_CYCLES cycles, then → RUN.
  - RUN: Core_Reset_n = 1. Each cycle, Cycles increments and saturates at all-ones. Each cycle with Datamem_Write = 1, Stores increments (saturating).
  - DONE: Core_Reset_n = 0 (core frozen); status holds. Start=1 → RESET with status cleared, the same as from IDLE.
- Mailbox hit: in RUN, Datamem_Write = 1, Addr == TOHOST_ADDR and Byteenable == 4'hF.
  - Effect: → DONE. Pass = (data == 1). Exitcode = data >> 1.
- Partial-byteenable writes to TOHOST_ADDR are not hits. They count as stores only.
- Timeout: in RUN, if TIMEOUT_CYCLES ≠ 0, the updated Cycles equals TIMEOUT_CYCLES and there is no hit that cycle → DONE with Timeout = 1, Pass = 0, Exitcode = 0.
- A mailbox hit on the same cycle as timeout: the hit wins, so Timeout = 0.
- Start is ignored in RESET and RUN.
- Asynchronous reset in any state returns every output to its reset value immediately, without waiting for a clock edge. The core is therefore forced into reset mid-run.
- Address comparison uses the full DATAWIDTH bits.

## Timing
- Start is sampled at edge E0:
  - Busy = 1 and Core_Reset_n = 0 from E0.
  - Core_Reset_n rises at edge E0+RST_CYCLES.
- The first RUN cycle follows E0+RST_CYCLES. The first counted RUN edge sets Cycles = 1.
- Mailbox hit sampled at edge Eh: at Eh, Done = 1, Busy = 0 and Core_Reset_n = 0. Cycles includes the hit cycle. The hit store itself is counted in Stores.
- Timeout: Done asserts at the edge where Cycles becomes TIMEOUT_CYCLES. The core runs exactly TIMEOUT_CYCLES cycles.
- Latency from Start to core running is RST_CYCLES cycles. The RUN-to-DONE latency after a hit is 1 edge.
- Done, Pass, Timeout and Exitcode are levels. They hold until the next Start or reset.

## Test plan
- Assert reset mid-cycle → all outputs go to 0 with no clock edge. Release reset, then 5 idle cycles → state stays IDLE and Core_Reset_n stays 0.
- RST_CYCLES=4, Start pulse → Busy rises, Core_Reset_n low for 4 edges then high. Start pulses during RESET and RUN change nothing.
- Store of 32'h1 (byteenable F) to 0x3FC on RUN cycle 10, plus 3 other stores earlier → Done=1, Pass=1, Exitcode=0, Cycles=10, Stores=4, Core_Reset_n=0.
- Store of 32'h0000000B to 0x3FC → Pass=0, Exitcode=5. Same address with byteenable 4'h3 earlier in the run → run continues and Stores increments.
- TIMEOUT_CYCLES=150 with no mailbox hit → Done and Timeout=1 at Cycles=150. Repeat with a hit on cycle 150 → Pass=1 and Timeout=0.
- Assert reset during RUN at cycle 40 → Core_Reset_n=0 and all status cleared asynchronously. Later Start from DONE → status clears and a full RESET/RUN sequence repeats. TIMEOUT_CYCLES=0 with 1000 cycles and no hit → never Done.
